// File: rtl/handshake_pkg.sv
// Shared constants for the valid/ready register slice pipeline.
// MODE selects which handshake paths carry a register.
package handshake_pkg;

    localparam int MODE_BYPASS = 0;
    localparam int MODE_FWD    = 1;
    localparam int MODE_BWD    = 2;
    localparam int MODE_FULL   = 3;

    // Width needed to count up to 2 beats per stage.
    function automatic int occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/handshake_slice_stage.sv
// One register slice between two valid/ready interfaces.
// Reports how many beats it holds (0..2).
module handshake_slice_stage
    import handshake_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = MODE_FWD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    if (MODE == MODE_BWD) begin : g_bwd
        logic             skid_valid;
        logic [WIDTH-1:0] skid_data;

        assign in_ready  = ~skid_valid;
        assign out_valid = skid_valid | in_valid;
        assign out_data  = skid_valid ? skid_data : in_data;
        assign count     = {1'b0, skid_valid};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                skid_valid <= 1'b0;
            end else if (out_ready) begin
                skid_valid <= 1'b0;
            end else if (in_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end else if (MODE == MODE_FULL) begin : g_full
        logic [WIDTH-1:0] mem [2];
        logic             head, tail;
        logic [1:0]       cnt;
        logic             push, pop;

        assign in_ready  = (cnt != 2'd2);
        assign out_valid = (cnt != 2'd0);
        assign out_data  = mem[head];
        assign count     = cnt;
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mem[0] <= '0;
                mem[1] <= '0;
                head   <= 1'b0;
                tail   <= 1'b0;
                cnt    <= 2'd0;
            end else if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
                cnt  <= 2'd0;
            end else begin
                if (push) begin
                    mem[tail] <= in_data;
                    tail      <= ~tail;
                end
                if (pop) head <= ~head;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 2'd1;
                    2'b01:   cnt <= cnt - 2'd1;
                    default: ;
                endcase
            end
        end
    end else begin : g_fwd
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        // Ready stays combinational so a full slice still streams at 1 beat/cycle.
        assign in_ready  = out_ready | ~valid_q;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign count     = {1'b0, valid_q};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
                if (in_valid) data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/handshake_slice_pipe.sv
// Chain of STAGES identical valid/ready slices with flush and occupancy.
// MODE_BYPASS collapses the whole pipe to wires.
module handshake_slice_pipe
    import handshake_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 1,
    parameter  int MODE   = MODE_FWD,
    localparam int OCC_W  = occ_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             master_valid,
    input  logic [WIDTH-1:0] master_data,
    output logic             master_ready,
    output logic             slave_valid,
    output logic [WIDTH-1:0] slave_data,
    input  logic             slave_ready,
    output logic [OCC_W-1:0] occupancy
);

    if (MODE == MODE_BYPASS) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = &{1'b0, clk, rst_n, flush};
        assign slave_valid   = master_valid;
        assign slave_data    = master_data;
        assign master_ready  = slave_ready;
        assign occupancy     = '0;
    end else begin : g_pipe
        // Nothing enters during reset or flush, so a pass-through path cannot leak a beat.
        logic                   accept_ok;
        logic [STAGES-1:0][1:0] cnt;
        logic [OCC_W-1:0]       occ_sum;

        assign accept_ok = rst_n & ~flush;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic             iv, ir, ov, ordy;
            logic [WIDTH-1:0] id, od;

            if (i == 0) begin : g_head
                assign iv = master_valid & accept_ok;
                assign id = master_data;
            end else begin : g_link
                assign iv = g_stage[i-1].ov;
                assign id = g_stage[i-1].od;
            end

            if (i == STAGES - 1) begin : g_tail
                assign ordy = slave_ready;
            end else begin : g_mid
                assign ordy = g_stage[i+1].ir;
            end

            handshake_slice_stage #(.WIDTH(WIDTH), .MODE(MODE)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .in_valid  (iv),
                .in_data   (id),
                .in_ready  (ir),
                .out_valid (ov),
                .out_data  (od),
                .out_ready (ordy),
                .count     (cnt[i])
            );
        end

        always_comb begin
            occ_sum = '0;
            for (int i = 0; i < STAGES; i++) occ_sum = occ_sum + OCC_W'(cnt[i]);
        end

        assign master_ready = g_stage[0].ir & accept_ok;
        assign slave_valid  = g_stage[STAGES-1].ov;
        assign slave_data   = g_stage[STAGES-1].od;
        assign occupancy    = occ_sum;
    end

endmodule

// File: tb/tb_handshake_slice_pipe.sv
// Randomised valid/ready/flush/reset traffic into every MODE and several depths,
// scored against an in-order queue of accepted beats.
module tb_handshake_slice_pipe;

    localparam int W    = 16;
    localparam int NCFG = 10;
    localparam int NCYC = 4000;
    localparam int CFG_MODE [NCFG] = '{0, 0, 1, 1, 2, 2, 3, 3, 1, 3};
    localparam int CFG_ST   [NCFG] = '{1, 3, 1, 3, 1, 3, 1, 3, 2, 2};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic armed = 1'b0;
    logic done  = 1'b0;
    int   nvec  = 0;
    int   nerr  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int M  = CFG_MODE[k];
        localparam int S  = CFG_ST[k];
        localparam int OW = $clog2(2 * S + 1);

        logic          mv   = 1'b0;
        logic [W-1:0]  md   = '0;
        logic          sr   = 1'b0;
        logic          mr, sv;
        logic [W-1:0]  sd;
        logic [OW-1:0] occ;

        logic [W-1:0]  qd [$];
        int            qt [$];
        int            cyc = 0;
        int            delivered = 0;
        logic          m_hs = 1'b0;
        logic          p_sv = 1'b0, p_sr = 1'b0, p_ok = 1'b0, p_rst = 1'b0;
        logic [W-1:0]  p_sd = '0;
        logic          ok, s_hs, mr0;
        logic [W-1:0]  exp_d;
        int            exp_t;

        handshake_slice_pipe #(.WIDTH(W), .STAGES(S), .MODE(M)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .master_valid (mv),
            .master_data  (md),
            .master_ready (mr),
            .slave_valid  (sv),
            .slave_data   (sd),
            .slave_ready  (sr),
            .occupancy    (occ)
        );

        // Master holds a beat until accepted; slave ready is free-running.
        always @(posedge clk) begin
            #1;
            if (!mv || m_hs) begin
                mv = ($urandom_range(0, 3) != 0);
                md = W'($urandom);
            end
            sr = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (armed) begin
                ok = rst_n & ~flush;
                if (M == 0) begin
                    chk($sformatf("c%0d/byp_occ", k), 64'(occ), 0);
                    chk($sformatf("c%0d/byp_valid", k), sv, mv);
                    chk($sformatf("c%0d/byp_data", k), sd, md);
                    chk($sformatf("c%0d/byp_ready", k), mr, sr);
                end else begin
                    chk($sformatf("c%0d/occ", k), 64'(occ), 64'(qd.size()));
                    if (!ok) chk($sformatf("c%0d/mr_blocked", k), mr, 1'b0);
                    else if (M == 1) chk($sformatf("c%0d/mr_fwd", k), mr, sr | (qd.size() < S));
                    else if (M == 2 && S == 1) chk($sformatf("c%0d/mr_bwd", k), mr, qd.size() == 0);
                    else if (M == 3 && S == 1) chk($sformatf("c%0d/mr_full", k), mr, qd.size() < 2);
                    if (p_rst && M != 2) chk($sformatf("c%0d/sv_after_rst", k), sv, 1'b0);
                    if (p_sv && !p_sr && p_ok) begin
                        chk($sformatf("c%0d/hold_valid", k), sv, 1'b1);
                        chk($sformatf("c%0d/hold_data", k), sd, p_sd);
                    end
                    // A registered ready must not react to slave_ready within the cycle.
                    if (M >= 2) begin
                        mr0 = mr;
                        sr  = ~sr;
                        #1;
                        chk($sformatf("c%0d/mr_registered", k), mr, mr0);
                        sr  = ~sr;
                        #1;
                    end
                end

                m_hs = mv & mr;
                s_hs = sv & sr;
                if (m_hs) begin
                    qd.push_back(md);
                    qt.push_back(cyc);
                end
                if (s_hs && (rst_n || M == 0)) begin
                    if (qd.size() == 0) begin
                        chk($sformatf("c%0d/spurious_beat", k), 1'b1, 1'b0);
                    end else begin
                        exp_d = qd.pop_front();
                        exp_t = qt.pop_front();
                        chk($sformatf("c%0d/data_order", k), sd, exp_d);
                        if (M == 1 || M == 3)
                            chk($sformatf("c%0d/latency", k), (cyc - exp_t) >= S, 1'b1);
                        delivered++;
                    end
                end
                if (M != 0 && (!rst_n || flush)) begin
                    qd.delete();
                    qt.delete();
                end

                p_sv  = sv;
                p_sr  = sr;
                p_sd  = sd;
                p_ok  = ok;
                p_rst = ~rst_n;
                cyc++;
            end
        end

        initial begin
            @(posedge done);
            chk($sformatf("c%0d/traffic", k), delivered > 200, 1'b1);
        end
    end

    initial begin
        @(posedge clk);
        #1 armed = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (NCYC) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1 done = 1'b1;
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
